// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial pattern scan detector.
`timescale 1ns/100ps
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_IDX_W  = $clog2(DEF_DATA_W + 1);

    // Width needed to hold the values 0..w inclusive.
    function automatic int idx_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/btn_rise_detect.sv
// Rising-edge detector for an already-debounced board input.
`timescale 1ns/100ps
module btn_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic in_d;

    // Next value of the input history flop.
    always_comb begin
        in_d = in;
    end

    // Input history register, cleared on reset so a button held through reset fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/pattern_scan_detector.sv
// Loads a word on a button edge, shifts it out MSB first and counts matches of a
// run-time pattern, overlapping or not.
`timescale 1ns/100ps
module pattern_scan_detector
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic [DATA_W-1:0] switch,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              busy,
    output logic              match_pulse,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              led
);

    localparam int IDX_W  = idx_width(DATA_W);
    localparam int FILL_W = idx_width(PAT_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    if (PAT_W < 1 || PAT_W > DATA_W) begin : g_bad_params
        $error("pattern_scan_detector: PAT_W must be in 1..DATA_W");
    end

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic                ovl_q, ovl_d;
    logic [PAT_W-1:0]    window_q, window_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pulse_q, pulse_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                led_q, led_d;

    logic                btn_rise;
    logic                accept;
    logic [PAT_W-1:0]    win_shift;
    logic [FILL_W-1:0]   fill_inc;
    logic                hit;

    btn_rise_detect u_btn (
        .clk  (clk),
        .rst  (rst),
        .in   (button),
        .rise (btn_rise)
    );

    assign accept = btn_rise & (state_q == IDLE);

    // Next-state and datapath logic; the match test looks at the post-shift window.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        pat_d     = pat_q;
        ovl_d     = ovl_q;
        window_d  = window_q;
        fill_d    = fill_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
        led_d     = led_q;

        win_shift = PAT_W'({window_q, data_q[DATA_W-1]});
        fill_inc  = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        hit       = (fill_inc == FULL) && (win_shift == pat_q);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SCAN;
                    data_d   = switch;
                    pat_d    = pattern;
                    ovl_d    = overlap;
                    window_d = '0;
                    fill_d   = '0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    led_d    = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            SCAN: begin
                data_d   = data_q << 1'b1;
                window_d = win_shift;
                // Non-overlapping mode restarts the fill so the next hit needs fresh bits.
                fill_d   = (hit && !ovl_q) ? '0 : fill_inc;
                pulse_d  = hit;
                if (hit) begin
                    cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                    led_d = 1'b1;
                end else begin
                    cnt_d = cnt_q;
                    led_d = led_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything including the held count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            pat_q    <= '0;
            ovl_q    <= 1'b0;
            window_q <= '0;
            fill_q   <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            pat_q    <= pat_d;
            ovl_q    <= ovl_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign match_pulse = pulse_q;
    assign match_cnt   = cnt_q;
    assign led         = led_q;

endmodule

// File: tb/tb_pattern_scan_detector.sv
// Directed bench for pattern_scan_detector: a per-cycle reference model plus literal pins.
`timescale 1ns/100ps
module tb_pattern_scan_detector;

    localparam int DW = 8;
    localparam int PW = 4;

    logic          clk;
    logic          rst;
    logic          button;
    logic [DW-1:0] switch;
    logic [PW-1:0] pattern;
    logic          overlap;

    logic          busy, match_pulse, done, led;
    logic [3:0]    match_cnt;
    logic          busy2, match_pulse2, done2, led2;
    logic [1:0]    match_cnt2;

    pattern_scan_detector #(.DATA_W(DW), .PAT_W(PW), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .button(button), .switch(switch), .pattern(pattern),
        .overlap(overlap), .busy(busy), .match_pulse(match_pulse), .done(done),
        .match_cnt(match_cnt), .led(led)
    );

    pattern_scan_detector #(.DATA_W(DW), .PAT_W(PW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .button(button), .switch(switch), .pattern(pattern),
        .overlap(overlap), .busy(busy2), .match_pulse(match_pulse2), .done(done2),
        .match_cnt(match_cnt2), .led(led2)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: match positions are worked out from the word when it is loaded.
    bit m_scan, m_done, m_prev;
    int m_j, m_cnt;
    bit m_hit [DW];
    bit e_busy, e_done, e_pulse;
    int obs_pulses, obs_dones;
    bit pulse_at_done;

    always @(posedge clk) begin
        bit s_rst, s_btn, s_ovl, idle, acc, ok;
        logic [DW-1:0] s_sw;
        logic [PW-1:0] s_pat;
        int next_start, st;
        s_rst = rst; s_btn = button; s_sw = switch; s_pat = pattern; s_ovl = overlap;
        e_pulse = 1'b0;
        e_done  = 1'b0;
        if (s_rst) begin
            m_scan = 1'b0; m_done = 1'b0; m_prev = 1'b0; m_j = 0; m_cnt = 0; e_busy = 1'b0;
        end else begin
            idle   = !m_scan && !m_done;
            acc    = s_btn && !m_prev && idle;
            m_prev = s_btn;
            if (m_scan) begin
                m_j++;
                if (m_hit[m_j-1]) begin
                    e_pulse = 1'b1;
                    m_cnt++;
                end
                if (m_j == DW) begin
                    m_scan = 1'b0; m_done = 1'b1; e_busy = 1'b0; e_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (acc) begin
                next_start = 0;
                for (int i = 0; i < DW; i++) begin
                    m_hit[i] = 1'b0;
                    st = i - PW + 1;
                    if (st >= 0 && st >= next_start) begin
                        ok = 1'b1;
                        for (int k = 0; k < PW; k++)
                            if (s_sw[DW-1-(st+k)] != s_pat[PW-1-k]) ok = 1'b0;
                        if (ok) begin
                            m_hit[i] = 1'b1;
                            if (!s_ovl) next_start = i + 1;
                        end
                    end
                end
                m_cnt = 0; m_scan = 1'b1; m_j = 0; e_busy = 1'b1;
            end
        end
        #0.5;
        chk("busy",   32'(busy),        32'(e_busy));
        chk("done",   32'(done),        32'(e_done));
        chk("pulse",  32'(match_pulse), 32'(e_pulse));
        chk("cnt",    32'(match_cnt),   32'((m_cnt > 15) ? 15 : m_cnt));
        chk("led",    32'(led),         32'(m_cnt != 0));
        chk("busy2",  32'(busy2),       32'(e_busy));
        chk("done2",  32'(done2),       32'(e_done));
        chk("pulse2", 32'(match_pulse2), 32'(e_pulse));
        chk("cnt2",   32'(match_cnt2),  32'((m_cnt > 3) ? 3 : m_cnt));
        chk("led2",   32'(led2),        32'(m_cnt != 0));
        if (match_pulse) obs_pulses++;
        if (done) begin
            obs_dones++;
            if (match_pulse) pulse_at_done = 1'b1;
        end
    end

    task automatic clear_obs();
        obs_pulses = 0; obs_dones = 0; pulse_at_done = 1'b0;
    endtask

    // One load, then scrambled inputs during the scan, then wait for completion.
    task automatic load(input logic [DW-1:0] sw, input logic [PW-1:0] pat, input logic ov);
        @(negedge clk);
        switch = sw; pattern = pat; overlap = ov; button = 1'b1;
        clear_obs();
        @(negedge clk);
        button = 1'b0; switch = ~sw; pattern = ~pat; overlap = ~ov;
        repeat (DW + 2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; button = 1'b0; switch = '0; pattern = '0; overlap = 1'b0;
        clear_obs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt",  32'(match_cnt), 32'd0);
        chk("rst_led",  32'(led), 32'd0);

        load(8'b00011010, 4'b1101, 1'b1);
        chk("t1_cnt", 32'(match_cnt), 32'd1);
        chk("t1_led", 32'(led), 32'd1);
        chk("t1_pulses", 32'(obs_pulses), 32'd1);
        chk("t1_dones", 32'(obs_dones), 32'd1);

        load(8'b10101010, 4'b1010, 1'b1);
        chk("t2o_cnt", 32'(match_cnt), 32'd3);
        chk("t2o_pulses", 32'(obs_pulses), 32'd3);
        load(8'b10101010, 4'b1010, 1'b0);
        chk("t2n_cnt", 32'(match_cnt), 32'd2);
        chk("t2n_pulses", 32'(obs_pulses), 32'd2);

        load(8'b00110111, 4'b0111, 1'b1);
        chk("t3_cnt", 32'(match_cnt), 32'd1);
        chk("t3_last", 32'(pulse_at_done), 32'd1);
        load(8'h00, 4'b0111, 1'b1);
        chk("t3z_cnt", 32'(match_cnt), 32'd0);
        chk("t3z_led", 32'(led), 32'd0);

        load(8'hFF, 4'hF, 1'b1);
        chk("t4_pulses", 32'(obs_pulses), 32'd5);
        chk("t4_cnt2", 32'(match_cnt2), 32'd3);
        chk("t4_cnt", 32'(match_cnt), 32'd5);

        // Held button: one scan only.
        @(negedge clk);
        switch = 8'b10011001; pattern = 4'b1001; overlap = 1'b1; button = 1'b1;
        clear_obs();
        repeat (20) @(negedge clk);
        button = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_held_dones", 32'(obs_dones), 32'd1);
        chk("t5_held_cnt", 32'(match_cnt), 32'd2);

        // Second rising edge during the scan is dropped.
        @(negedge clk);
        switch = 8'b11110000; pattern = 4'b0000; overlap = 1'b0; button = 1'b1;
        clear_obs();
        @(negedge clk);
        button = 1'b0;
        repeat (2) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        repeat (DW + 4) @(negedge clk);
        chk("t5_retrig_dones", 32'(obs_dones), 32'd1);
        chk("t5_retrig_cnt", 32'(match_cnt), 32'd1);

        // Reset mid-scan after one match has already been counted.
        @(negedge clk);
        switch = 8'b11110000; pattern = 4'b1111; overlap = 1'b1; button = 1'b1;
        clear_obs();
        @(negedge clk);
        button = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_pre_cnt", 32'(match_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cnt", 32'(match_cnt), 32'd0);
        chk("t6_led", 32'(led), 32'd0);
        repeat (DW) @(negedge clk);
        chk("t6_no_done", 32'(obs_dones), 32'd0);
        load(8'b01011011, 4'b1011, 1'b1);
        chk("t6_fresh_cnt", 32'(match_cnt), 32'd2);
        chk("t6_fresh_dones", 32'(obs_dones), 32'd1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
